// File: rtl/acl_spi_responder.sv
// SPI-mode-0 responder emulating an ADXL362-style accelerometer: 64-byte register file, burst read/write.
// Optional soft reset via register 0x1F is enabled by defining ACL_RESP_SOFTRESET_EN.
module acl_spi_responder #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  DEVID       = 8'hAD
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       CSN,
   input  logic       SCLK,
   input  logic       MOSI,
   output logic       MISO,
   output logic       miso_oe,
   input  logic [7:0] x_in,
   input  logic [7:0] y_in,
   input  logic       sample_stb,
   output logic       wr_valid,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       bad_inst
);

   localparam int unsigned NREGS = 64;
   localparam int unsigned AW    = 6;

   typedef enum logic [2:0] {S_IDLE, S_INST, S_ADDR, S_DATA, S_IGNORE} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] csn_sync, sclk_sync, mosi_sync;
   logic                   csn_d, sclk_d;
   logic                   csn_s, sclk_s, mosi_s;
   logic                   sclk_rise, sclk_fall, csn_rise, csn_fall;
   logic [2:0]             bit_cnt;
   logic [7:0]             rx_sh, tx_sh;
   logic [7:0]             rx_next;
   logic [AW-1:0]          ptr, ptr_inc;
   logic                   is_read;
   logic [7:0]             regs [NREGS];
`ifdef ACL_RESP_SOFTRESET_EN
   logic                   armed;
`endif

   function automatic logic [7:0] reset_val(input logic [AW-1:0] idx);
      case (idx)
         6'h00:   return DEVID;
         6'h01:   return 8'h1D;
         6'h02:   return 8'hF2;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic writable(input logic [AW-1:0] p);
      return (p >= 6'h1F) && (p <= 6'h2E);
   endfunction

   // CSN synchronizer resets low so a reset taken with CSN held low never yields a false select edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csn_sync  <= '0;
         sclk_sync <= '0;
         mosi_sync <= '0;
         csn_d     <= 1'b0;
         sclk_d    <= 1'b0;
      end else begin
         csn_sync  <= {csn_sync[SYNC_STAGES-2:0], CSN};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
         csn_d     <= csn_s;
         sclk_d    <= sclk_s;
      end
   end

   assign csn_s     = csn_sync[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign csn_rise  = csn_s & ~csn_d;
   assign csn_fall  = ~csn_s & csn_d;
   assign rx_next   = {rx_sh[6:0], mosi_s};
   assign ptr_inc   = ptr + 6'd1;

   // Protocol FSM and register file; an SPI write is assigned after sample_stb so it takes priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         bit_cnt  <= 3'd0;
         rx_sh    <= 8'h00;
         tx_sh    <= 8'h00;
         ptr      <= '0;
         is_read  <= 1'b0;
         MISO     <= 1'b0;
         miso_oe  <= 1'b0;
         wr_valid <= 1'b0;
         wr_addr  <= 8'h00;
         wr_data  <= 8'h00;
         bad_inst <= 1'b0;
`ifdef ACL_RESP_SOFTRESET_EN
         armed    <= 1'b0;
`endif
         for (int unsigned i = 0; i < NREGS; i++) regs[AW'(i)] <= reset_val(AW'(i));
      end else begin
         wr_valid <= 1'b0;
         bad_inst <= 1'b0;
         if (sample_stb) begin
            regs[6'h08] <= x_in;
            regs[6'h09] <= y_in;
         end
         if (csn_rise) begin
            state   <= S_IDLE;
            bit_cnt <= 3'd0;
            MISO    <= 1'b0;
            miso_oe <= 1'b0;
`ifdef ACL_RESP_SOFTRESET_EN
            if (armed) begin
               armed <= 1'b0;
               for (int unsigned i = 0; i < NREGS; i++) regs[AW'(i)] <= reset_val(AW'(i));
            end
`endif
         end else begin
            case (state)
               S_IDLE: begin
                  if (csn_fall) begin
                     state   <= S_INST;
                     bit_cnt <= 3'd0;
                  end
               end
               S_INST: begin
                  if (sclk_rise) begin
                     rx_sh   <= rx_next;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        case (rx_next)
                           8'h0A: begin
                              state   <= S_ADDR;
                              is_read <= 1'b0;
                           end
                           8'h0B: begin
                              state   <= S_ADDR;
                              is_read <= 1'b1;
                           end
                           default: begin
                              state    <= S_IGNORE;
                              bad_inst <= 1'b1;
                           end
                        endcase
                     end
                  end
               end
               S_ADDR: begin
                  if (sclk_rise) begin
                     rx_sh   <= rx_next;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        ptr     <= rx_next[AW-1:0];
                        tx_sh   <= regs[rx_next[AW-1:0]];
                        miso_oe <= is_read;
                        state   <= S_DATA;
                     end
                  end
               end
               S_DATA: begin
                  if (is_read) begin
                     if (sclk_fall) begin
                        MISO  <= tx_sh[7];
                        tx_sh <= {tx_sh[6:0], 1'b0};
                     end
                     if (sclk_rise) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                           ptr   <= ptr_inc;
                           tx_sh <= regs[ptr_inc];
                        end
                     end
                  end else if (sclk_rise) begin
                     rx_sh   <= rx_next;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        if (writable(ptr)) begin
                           regs[ptr] <= rx_next;
                           wr_valid  <= 1'b1;
                           wr_addr   <= {2'b00, ptr};
                           wr_data   <= rx_next;
`ifdef ACL_RESP_SOFTRESET_EN
                           if (ptr == 6'h1F) armed <= (rx_next == 8'h52);
`endif
                        end
                        ptr <= ptr_inc;
                     end
                  end
               end
               S_IGNORE: ;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_acl_spi_responder.sv
// Bench for acl_spi_responder: SPI master driver, transaction-level register model, cycle monitor.
module tb_acl_spi_responder;

   logic       clk = 1'b0;
   logic       rst, CSN, SCLK, MOSI, MISO, miso_oe, sample_stb;
   logic [7:0] x_in, y_in, wr_addr, wr_data;
   logic       wr_valid, bad_inst;

   always #5 clk = ~clk;

   acl_spi_responder #(.SYNC_STAGES(2), .DEVID(8'hAD)) dut (
      .clk(clk), .rst(rst), .CSN(CSN), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
      .miso_oe(miso_oe), .x_in(x_in), .y_in(y_in), .sample_stb(sample_stb),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .bad_inst(bad_inst)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [7:0]  mdl [64];
   logic [15:0] wr_q [$];
   int          bad_exp  = 0;
   int          bad_seen = 0;
   bit          idle_chk = 1'b0;
   logic [7:0]  tx [16];
   logic [7:0]  rx [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [7:0] rst_val(input int i);
      case (i)
         0:       return 8'hAD;
         1:       return 8'h1D;
         2:       return 8'hF2;
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) mdl[i] = rst_val(i);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Mode 0: drive MOSI while SCLK low, sample MISO just after raising SCLK.
   task automatic send_bit(input logic b, output logic mi, output logic oe);
      MOSI = b;
      wait_clk(8);
      SCLK = 1'b1;
      #1;
      mi = MISO;
      oe = miso_oe;
      wait_clk(8);
      SCLK = 1'b0;
   endtask

   task automatic csn_low();
      idle_chk = 1'b0;
      CSN = 1'b0;
      wait_clk(8);
   endtask

   task automatic csn_high();
      wait_clk(8);
      CSN = 1'b1;
      wait_clk(6);
      idle_chk = 1'b1;
   endtask

   task automatic sample(input logic [7:0] x, input logic [7:0] y);
      @(negedge clk);
      x_in = x;
      y_in = y;
      sample_stb = 1'b1;
      @(negedge clk);
      sample_stb = 1'b0;
      mdl[8] = x;
      mdl[9] = y;
   endtask

   // One CSN frame: nbytes whole bytes from tx[], then extra_bits of tx[nbytes] before CSN rises.
   task automatic txn(input int nbytes, input int extra_bits);
      logic [7:0] erx [16];
      logic       eoe [16];
      logic [7:0] inst;
      logic [5:0] a, p;
      logic       mi, oe, oe_any, oe_all;
`ifdef ACL_RESP_SOFTRESET_EN
      bit         arm = 1'b0;
`endif
      inst = tx[0];
      a    = tx[1][5:0];
      for (int i = 0; i < 16; i++) begin
         erx[i] = 8'h00;
         eoe[i] = 1'b0;
      end
      if (inst != 8'h0A && inst != 8'h0B) bad_exp++;
      for (int i = 2; i < nbytes; i++) begin
         p = 6'(a + 6'(i - 2));
         if (inst == 8'h0B) begin
            erx[i] = mdl[p];
            eoe[i] = 1'b1;
         end else if (inst == 8'h0A && p >= 6'h1F && p <= 6'h2E) begin
            mdl[p] = tx[i];
            wr_q.push_back({2'b00, p, tx[i]});
`ifdef ACL_RESP_SOFTRESET_EN
            if (p == 6'h1F) arm = (tx[i] == 8'h52);
`endif
         end
      end
      csn_low();
      for (int i = 0; i < nbytes; i++) begin
         oe_any = 1'b0;
         oe_all = 1'b1;
         for (int b = 7; b >= 0; b--) begin
            send_bit(tx[i][b], mi, oe);
            rx[i][b] = mi;
            oe_any |= oe;
            oe_all &= oe;
         end
         chk("miso_oe_byte", 32'({oe_any, oe_all}), 32'({eoe[i], eoe[i]}));
      end
      for (int b = 0; b < extra_bits; b++) send_bit(tx[nbytes][7-b], mi, oe);
      csn_high();
`ifdef ACL_RESP_SOFTRESET_EN
      if (arm) model_reset();
`endif
      for (int i = 0; i < nbytes; i++) chk("miso_byte", 32'(rx[i]), 32'(erx[i]));
      chk("wr_missing", 32'(wr_q.size()), 32'd0);
      chk("bad_inst_count", 32'(bad_seen), 32'(bad_exp));
   endtask

   task automatic set_tx(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      for (int i = 0; i < 16; i++) tx[i] = 8'($urandom);
      tx[0] = b0;
      tx[1] = b1;
      tx[2] = b2;
   endtask

   // Cycle monitor: write strobes against the model queue, idle pins quiet.
   always @(negedge clk) begin
      logic [15:0] e;
      if (!rst) begin
         if (wr_valid) begin
            if (wr_q.size() == 0) chk("wr_valid_unexpected", 32'(wr_valid), 32'd0);
            else begin
               e = wr_q.pop_front();
               chk("wr_addr_data", 32'({wr_addr, wr_data}), 32'(e));
            end
         end
         if (bad_inst) bad_seen++;
         if (idle_chk) chk("idle_pins", 32'({MISO, miso_oe}), 32'd0);
      end
   end

   initial begin
      logic mi, oe;
      logic [7:0] ign [3];
      logic [7:0] a8;
      int kind, n;

      rst = 1'b1; CSN = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
      sample_stb = 1'b0; x_in = 8'h00; y_in = 8'h00;
      model_reset();
      wait_clk(3);
      #1;
      chk("reset_outputs", 32'({MISO, miso_oe, wr_valid, bad_inst, wr_addr, wr_data}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      wait_clk(10);
      idle_chk = 1'b1;

      set_tx(8'h0B, 8'h00, 8'h00);
      txn(5, 0);
      chk("devid_burst", 32'({rx[2], rx[3], rx[4]}), 32'hAD1DF2);

      set_tx(8'h0A, 8'h2D, 8'h0A);
      txn(3, 0);
      set_tx(8'h0B, 8'h2D, 8'h00);
      txn(3, 0);
      chk("readback_2d", 32'(rx[2]), 32'h0A);

      sample(8'h5A, 8'hC3);
      set_tx(8'h0B, 8'h08, 8'h00);
      txn(4, 0);
      chk("sample_xy", 32'({rx[2], rx[3]}), 32'h5AC3);

      set_tx(8'h0B, 8'h3F, 8'h00);
      txn(4, 0);
      chk("wrap_burst", 32'({rx[2], rx[3]}), 32'h00AD);

      set_tx(8'h0C, 8'h00, 8'h00);
      txn(4, 0);
      chk("bad_inst_once", 32'(bad_seen), 32'd1);
      set_tx(8'h0B, 8'h01, 8'h00);
      txn(3, 0);
      chk("after_bad_inst", 32'(rx[2]), 32'h1D);

      set_tx(8'h0A, 8'h08, 8'h77);
      txn(3, 0);
      set_tx(8'h0B, 8'h08, 8'h00);
      txn(3, 0);
      chk("ro_reg_08", 32'(rx[2]), 32'h5A);

      set_tx(8'h0A, 8'h20, 8'hFF);
      txn(2, 5);
      set_tx(8'h0B, 8'h20, 8'h00);
      txn(3, 0);
      chk("partial_write", 32'(rx[2]), 32'h00);

      // Reset in the middle of a read data byte; the rest of the frame must be ignored.
      set_tx(8'h0B, 8'h00, 8'h00);
      csn_low();
      for (int i = 0; i < 2; i++)
         for (int b = 7; b >= 0; b--) send_bit(tx[i][b], mi, oe);
      for (int b = 0; b < 3; b++) send_bit(1'b0, mi, oe);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_midread", 32'({MISO, miso_oe, wr_valid, bad_inst, wr_addr, wr_data}), 32'd0);
      wait_clk(2);
      rst = 1'b0;
      model_reset();
      wait_clk(4);
      ign[0] = 8'h0A; ign[1] = 8'h25; ign[2] = 8'h11;
      for (int i = 0; i < 3; i++) begin
         for (int b = 7; b >= 0; b--) begin
            send_bit(ign[i][b], mi, oe);
            rx[i][b] = mi;
         end
         chk("ignored_frame_miso", 32'(rx[i]), 32'd0);
      end
      csn_high();
      chk("ignored_frame_bad", 32'(bad_seen), 32'(bad_exp));
      set_tx(8'h0B, 8'h25, 8'h00);
      txn(3, 0);
      chk("ignored_write_25", 32'(rx[2]), 32'h00);
      set_tx(8'h0B, 8'h2D, 8'h00);
      txn(3, 0);
      chk("rst_cleared_2d", 32'(rx[2]), 32'h00);

`ifdef ACL_RESP_SOFTRESET_EN
      set_tx(8'h0A, 8'h2D, 8'h0A);
      txn(3, 0);
      set_tx(8'h0A, 8'h1F, 8'h52);
      txn(3, 0);
      set_tx(8'h0B, 8'h2D, 8'h00);
      txn(3, 0);
      chk("softreset_2d", 32'(rx[2]), 32'h00);
      set_tx(8'h0B, 8'h1F, 8'h00);
      txn(3, 0);
      chk("softreset_1f", 32'(rx[2]), 32'h00);
`else
      set_tx(8'h0A, 8'h1F, 8'h52);
      txn(3, 0);
      set_tx(8'h0B, 8'h1F, 8'h00);
      txn(3, 0);
      chk("plain_1f", 32'(rx[2]), 32'h52);
`endif

      for (int it = 0; it < 28; it++) begin
         kind = int'($urandom_range(0, 3));
         case (kind)
            0: begin
               set_tx(8'h0B, 8'($urandom), 8'h00);
               txn(2 + int'($urandom_range(1, 4)), 0);
            end
            1: begin
               a8 = 8'($urandom_range(0, 3) << 6) | 8'(28 + $urandom_range(0, 21));
               set_tx(8'h0A, a8, 8'($urandom));
               n = 2 + int'($urandom_range(1, 3));
               txn(n, int'($urandom_range(0, 1)) * int'($urandom_range(1, 7)));
            end
            2: begin
               sample(8'($urandom), 8'($urandom));
               set_tx(8'h0B, 8'h08, 8'h00);
               txn(4, 0);
            end
            default: begin
               a8 = 8'($urandom);
               if (a8 == 8'h0A || a8 == 8'h0B) a8 = 8'hFF;
               set_tx(a8, 8'($urandom), 8'($urandom));
               txn(3, 0);
            end
         endcase
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/acl_spi_responder.md
# acl_spi_responder

SPI-slave model of the 3-axis accelerometer (ADXL362-style command set) that answers the accelerometer SPI master: it decodes the write instruction (0x0A) and the read instruction (0x0B), an 8-bit register address, and a stream of data bytes. It holds a 64-byte register file with auto-incrementing burst access, and exposes write strobes plus sample-load inputs to the fabric. It sits on the board-side SPI pins in place of the sensor, for closed-loop simulation and for FPGA-to-FPGA emulation.

## Interface
- `SYNC_STAGES`, 2: depth of the synchronizer on CSN, SCLK and MOSI (≥2).
- `DEVID`, 8'hAD: reset content of register 0x00.
- `clk` in 1: system clock; must run at least 8× SCLK.
- `rst` in 1: reset; one clock, asynchronous, active-high.
- `CSN` in 1: SPI chip select, active-low.
- `SCLK` in 1: SPI clock, mode 0 (CPOL=0, CPHA=0), MSB first.
- `MOSI` in 1: serial data from the master.
- `MISO` out 1: serial data to the master; 0 when not driven.
- `miso_oe` out 1: high while CSN is low and a read data phase is active.
- `x_in`, `y_in` in 8 each: sample values.
- `sample_stb` in 1: loads `x_in`→reg 0x08 and `y_in`→reg 0x09.
- `wr_valid` out 1: one-cycle pulse when a register is written over SPI.
- `wr_addr` out 8, `wr_data` out 8: address and data of that write.
- `bad_inst` out 1: one-cycle pulse when an unknown instruction is received.

## Operation
- Reset values: MISO=0, miso_oe=0, wr_valid=0, wr_addr=0, wr_data=0, bad_inst=0, FSM=IDLE, bit counter=0.
- Register file after reset: 0x00=DEVID, 0x01=8'h1D, 0x02=8'hF2; all other registers 0.
- Writable range: 0x1F–0x2E. Writes elsewhere are dropped, with no wr_valid pulse. All 64 addresses are readable.
- Address bits [7:6] are ignored; the register index is addr[5:0].
- Edge detection: synchronized SCLK rise/fall and CSN fall/rise, each a single-cycle pulse.
- FSM states:
  - IDLE: CSN fall → INST, bit counter cleared.
  - INST: shift MOSI on each SCLK rise. After 8 bits:
    - 0x0A → ADDR with the write flag set.
    - 0x0B → ADDR with the read flag set.
    - anything else → IGNORE, and pulse bad_inst.
  - ADDR: after 8 bits, latch the pointer → DATA. On a read, load the shift-out register from reg[ptr] in the same cycle.
  - DATA, write: after each 8 bits, commit to reg[ptr] if the pointer is writable and pulse wr_valid; then ptr+1.
  - DATA, read: shift out MSB first. After the 8th SCLK rise, ptr+1 and reload the shift register from the new pointer.
  - IGNORE: hold until CSN rises.
- Any state on CSN rise → IDLE. A partial byte is discarded and never written; miso_oe drops.
- Pointer wraps 0x3F→0x00 during bursts.
- Simultaneous sample_stb and an SPI write to 0x08/0x09: the SPI write wins.
- A read byte already in the shift register is a snapshot; sample_stb does not alter it mid-byte.

## Timing
- SCLK/CSN edges are detected SYNC_STAGES+1 clk after the pin transition.
- MISO changes 1 clk after a detected SCLK fall.
- The first read data bit (bit 7) is presented on the SCLK fall that follows the last address bit.
- wr_valid fires 1 clk after the 8th detected SCLK rise of a data byte.
- bad_inst fires 1 clk after the 8th detected SCLK rise of the instruction.
- Reset asserted mid-transaction: immediate return to the reset values above. The transaction is ignored until the next CSN fall after reset deassertion.

## Configuration
- `ACL_RESP_SOFTRESET_EN` defined: writing 8'h52 to 0x1F arms a soft reset. On the next CSN rise the register file returns to its reset contents; 0x1F reads 0 afterwards.
- `ACL_RESP_SOFTRESET_EN` undefined: 0x1F is an ordinary writable register with no side effect.

## Test plan
- Read 0x0B,0x00 with a 3-byte burst → MISO bytes 0xAD,0x1D,0xF2; miso_oe high only during the data phase.
- Write 0x0A,0x2D,0x0A → wr_valid one pulse with wr_addr=0x2D, wr_data=0x0A; a later read of 0x2D returns 0x0A.
- sample_stb with x_in=0x5A, y_in=0xC3, then read 0x0B,0x08 as a 2-byte burst → 0x5A,0xC3. Burst read from 0x3F → 0x3F contents, then 0xAD (wrap).
- Instruction 0x0C → bad_inst pulse; no MISO activity; next transaction decodes normally. Write to 0x08 → no wr_valid; value unchanged.
- CSN raised after 5 data bits of a write to 0x20 → register unchanged, FSM in IDLE. rst pulsed mid-read → outputs at reset values.
- With ACL_RESP_SOFTRESET_EN: write 0x2D=0x0A, then 0x1F=0x52, then CSN rise → 0x2D reads 0x00 and 0x1F reads 0x00.
